// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer read arbiter slice.
// Holds the frame geometry, requester address width, run limit for the
// display, pixel/address types and the read-owner encoding.
package fb_pkg;

  localparam int FB_W         = 320;
  localparam int FB_H         = 240;
  localparam int PIX_COUNT    = FB_W * FB_H;  // 76800 valid addresses
  localparam int AW           = 17;
  localparam int MAX_DISP_RUN = 4;
  localparam int RUN_W        = 3;             // holds 0..MAX_DISP_RUN

  typedef logic [3:0]    pix_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_TRK  = 2'd2
  } owner_e;

  localparam addr_t PIX_LIMIT = addr_t'(PIX_COUNT);

  // True when the address maps onto a real pixel of the frame.
  function automatic logic addr_in_range(input addr_t a);
    return (a < PIX_LIMIT);
  endfunction

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Bundle of requester handshakes and frame-buffer read-port signals.
//   slave  : arbiter side (takes requests, drives grants/returns and the
//            frame-buffer read enable/address, takes read data)
//   master : requesters plus frame-buffer side (the opposite directions)
interface fb_read_arbiter_if;
  import fb_pkg::*;

  logic        disp_req;
  addr_t       disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  pix_t        disp_rdata;
  logic        disp_err;

  logic        trk_req;
  addr_t       trk_addr;
  logic        trk_gnt;
  logic        trk_rvalid;
  pix_t        trk_rdata;
  logic        trk_err;

  logic        fb_oe;
  logic [31:0] fb_rAddr;
  pix_t        fb_rData;

  modport slave (
    input  disp_req, disp_addr, trk_req, trk_addr, fb_rData,
    output disp_gnt, disp_rvalid, disp_rdata, disp_err,
    output trk_gnt, trk_rvalid, trk_rdata, trk_err,
    output fb_oe, fb_rAddr
  );

  modport master (
    output disp_req, disp_addr, trk_req, trk_addr, fb_rData,
    input  disp_gnt, disp_rvalid, disp_rdata, disp_err,
    input  trk_gnt, trk_rvalid, trk_rdata, trk_err,
    input  fb_oe, fb_rAddr
  );

endinterface

// File: rtl/fb_rr_starve_ctr.sv
// Counts consecutive display grants taken while the tracker is waiting and
// raises trk_force_o once the display has used up its allowed run.
// Ports:
//   clk, reset   : read clock, synchronous active-high reset
//   trk_req_i    : tracker is requesting this cycle
//   disp_gnt_i   : display was granted this cycle
//   trk_gnt_i    : tracker was granted this cycle
//   trk_force_o  : tracker must win the next contended cycle
module fb_rr_starve_ctr
  import fb_pkg::*;
#(
  parameter int MAX_RUN = MAX_DISP_RUN
) (
  input  logic clk,
  input  logic reset,
  input  logic trk_req_i,
  input  logic disp_gnt_i,
  input  logic trk_gnt_i,
  output logic trk_force_o
);

  localparam logic [RUN_W-1:0] MAX_Q = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] ONE_Q = RUN_W'(1);

  logic [RUN_W-1:0] run_cnt_q;
  logic [RUN_W-1:0] run_cnt_d;

  // Next run count: a tracker that is idle or served resets the run.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!trk_req_i || trk_gnt_i) begin
      run_cnt_d = {RUN_W{1'b0}};
    end else if (disp_gnt_i && (run_cnt_q < MAX_Q)) begin
      run_cnt_d = run_cnt_q + ONE_Q;
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // Run count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= {RUN_W{1'b0}};
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign trk_force_o = (run_cnt_q == MAX_Q);

endmodule

// File: rtl/fb_read_arbiter.sv
// Shares the frame-buffer read port between the display scanner (priority)
// and the tracker. One grant per cycle, data returned to the owner one
// cycle later; the tracker is forced through after a bounded display run.
// Ports:
//   clk   : read-side clock (same as frame-buffer read port)
//   reset : synchronous active-high reset
//   bus   : requester handshakes and frame-buffer read port (slave side)
module fb_read_arbiter
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fb_read_arbiter_if.slave  bus
);

  logic   disp_gnt;
  logic   trk_gnt;
  logic   any_gnt;
  logic   trk_force;
  addr_t  gnt_addr;
  addr_t  addr_sel;
  logic   fb_oe;

  // owner_q != OWN_NONE doubles as the in-flight flag.
  owner_e owner_q, owner_d;
  logic   err_q, err_d;
  addr_t  last_addr_q, last_addr_d;

  fb_rr_starve_ctr #(.MAX_RUN(MAX_DISP_RUN)) u_ctr (
    .clk         (clk),
    .reset       (reset),
    .trk_req_i   (bus.trk_req),
    .disp_gnt_i  (disp_gnt),
    .trk_gnt_i   (trk_gnt),
    .trk_force_o (trk_force)
  );

  // Grant: display first unless its run is exhausted while the tracker waits.
  always_comb begin
    disp_gnt = 1'b0;
    trk_gnt  = 1'b0;
    if (reset) begin
      disp_gnt = 1'b0;
      trk_gnt  = 1'b0;
    end else if (bus.disp_req && !(bus.trk_req && trk_force)) begin
      disp_gnt = 1'b1;
    end else if (bus.trk_req) begin
      trk_gnt = 1'b1;
    end else begin
      disp_gnt = 1'b0;
      trk_gnt  = 1'b0;
    end
  end

  // Issue: out-of-range addresses are presented but never enabled.
  always_comb begin
    any_gnt  = disp_gnt | trk_gnt;
    gnt_addr = disp_gnt ? bus.disp_addr : bus.trk_addr;
    if (any_gnt) begin
      fb_oe    = addr_in_range(gnt_addr);
      addr_sel = gnt_addr;
    end else begin
      fb_oe    = 1'b0;
      addr_sel = last_addr_q;
    end
  end

  // Next-state for owner, error flag and last issued address.
  always_comb begin
    owner_d     = OWN_NONE;
    err_d       = 1'b0;
    last_addr_d = last_addr_q;
    if (disp_gnt) begin
      owner_d     = OWN_DISP;
      err_d       = !addr_in_range(gnt_addr);
      last_addr_d = gnt_addr;
    end else if (trk_gnt) begin
      owner_d     = OWN_TRK;
      err_d       = !addr_in_range(gnt_addr);
      last_addr_d = gnt_addr;
    end else begin
      owner_d     = OWN_NONE;
      err_d       = 1'b0;
      last_addr_d = last_addr_q;
    end
  end

  // Owner, error and last-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      err_q       <= 1'b0;
      last_addr_q <= '0;
    end else begin
      owner_q     <= owner_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Return path; gated by reset so a read in flight at reset is dropped.
  always_comb begin
    bus.disp_rvalid = 1'b0;
    bus.disp_err    = 1'b0;
    bus.disp_rdata  = 4'd0;
    bus.trk_rvalid  = 1'b0;
    bus.trk_err     = 1'b0;
    bus.trk_rdata   = 4'd0;
    if (reset) begin
      bus.disp_rvalid = 1'b0;
      bus.trk_rvalid  = 1'b0;
    end else begin
      case (owner_q)
        OWN_DISP: begin
          bus.disp_rvalid = 1'b1;
          bus.disp_err    = err_q;
          bus.disp_rdata  = err_q ? 4'd0 : bus.fb_rData;
        end
        OWN_TRK: begin
          bus.trk_rvalid = 1'b1;
          bus.trk_err    = err_q;
          bus.trk_rdata  = err_q ? 4'd0 : bus.fb_rData;
        end
        default: begin
          bus.disp_rvalid = 1'b0;
          bus.trk_rvalid  = 1'b0;
        end
      endcase
    end
  end

  assign bus.disp_gnt = disp_gnt;
  assign bus.trk_gnt  = trk_gnt;
  assign bus.fb_oe    = fb_oe;
  assign bus.fb_rAddr = {{(32-AW){1'b0}}, addr_sel};

endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Shares the single read port of the 4-bit QVGA frame buffer between two requesters: the display scanner (priority) and the object-tracking engine.
- Issues one read per cycle and returns data to the owner of each read one cycle after grant.
- Applies a bounded-starvation rule so the tracker still progresses during continuous display traffic.
- Sits between the display/tracker logic and the frame buffer read side, in the read clock domain.

Parameters:
- FB_W, 320, frame width in pixels
- FB_H, 240, frame height in pixels
- PIX_COUNT, FB_W*FB_H (76800), number of valid addresses
- MAX_DISP_RUN, 4, consecutive display grants allowed while the tracker waits
- AW, 17, requester address width

Ports:
- clk  in  1  read-side clock; same clock as the frame buffer read port
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read request; held until granted
- disp_addr  in  AW  display pixel address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  4  display read data
- disp_err  out  1  with disp_rvalid: address was out of range
- trk_req  in  1  tracker read request; held until granted
- trk_addr  in  AW  tracker pixel address
- trk_gnt  out  1  tracker request accepted this cycle
- trk_rvalid  out  1  tracker read data valid
- trk_rdata  out  4  tracker read data
- trk_err  out  1  with trk_rvalid: address was out of range
- fb_oe  out  1  to the frame buffer read enable
- fb_rAddr  out  32  to the frame buffer read address, zero-extended from AW
- fb_rData  in  4  from the frame buffer; valid the cycle after fb_oe

Behaviour:
- Reset: the owner register, error register, in-flight flag and run counter are cleared.
  - All rvalid, err and rdata outputs are 0 in the cycle after reset is sampled.
  - While reset is high, gnt and fb_oe are forced to 0.
  - A read in flight when reset is asserted is dropped; no rvalid follows.
- Grant is combinational and made in the same cycle as the request:
  - Only disp_req: display granted.
  - Only trk_req: tracker granted.
  - Both, run_cnt < MAX_DISP_RUN: display granted.
  - Both, run_cnt == MAX_DISP_RUN: tracker granted.
  - At most one gnt per cycle. A requester not granted keeps req and addr stable.
- run_cnt, 0..MAX_DISP_RUN, saturating:
  - Increments on a display grant while trk_req is high.
  - Clears on a tracker grant, or in any cycle trk_req is low.
- Issue, in the grant cycle:
  - fb_rAddr = granted address, zero-extended.
  - fb_oe = 1 only if the address < PIX_COUNT.
  - With no grant: fb_oe = 0; fb_rAddr holds its previous value, registered as the last issued address; reset value 0.
- Return, exactly 1 cycle after grant:
  - Owner register selects which rvalid pulses for one cycle.
  - Owner's rdata = fb_rData for an in-range address, or 0 with err = 1 for an out-of-range address.
  - The non-owner's rdata is 0.
- Throughput: back-to-back grants every cycle. Responses keep grant order and never overlap, since latency is fixed.
- Addresses PIX_COUNT..2^AW-1 never reach the memory. Address PIX_COUNT-1 (76799) is valid.

Decomposition:
- Package fb_pkg holds:
  - FB_W, FB_H, PIX_COUNT
  - Pixel type (4-bit)
  - Address type (AW bits)
  - Owner enum {OWN_NONE, OWN_DISP, OWN_TRK}
- Natural sub-module: fb_rr_starve_ctr, which holds the run counter and produces the tracker-forced signal.
- Issue and return logic stay in the top module.

Test Plan:
- Display-only: disp_req with addresses 0, 1, 2 on consecutive cycles -> disp_gnt high each cycle; disp_rvalid in cycles +1..+3 with the preloaded memory values; trk_rvalid stays 0.
- Tracker-only: trk_addr = 76799 -> trk_gnt; one cycle later trk_rvalid = 1 with the correct data and trk_err = 0.
- Contention, MAX_DISP_RUN = 4, both requesting continuously -> grant pattern D, D, D, D, T repeating; run_cnt returns to 0 after each T.
- Out of range: disp_addr = 76800 -> disp_gnt = 1, fb_oe = 0; next cycle disp_rvalid = 1, disp_err = 1, disp_rdata = 0.
- Reset mid-read: grant to the tracker, assert reset the next cycle -> no trk_rvalid; all outputs 0; run_cnt = 0 after release.
- Alternating requests with trk_req dropping between them -> run_cnt clears; the display always wins when trk_req is high and run_cnt < 4.
